// File: rtl/wb_regfile_pkg.sv
// Shared constants and types for the write-back register file.
// Widths, enable levels and the reset/bubble values live here.
package wb_regfile_pkg;

  localparam int REG_BUS_W  = 32;
  localparam int REG_ADDR_W = 5;
  localparam int REG_NUM    = 32;

  localparam logic RST_ENABLE    = 1'b1;
  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;
  localparam logic READ_ENABLE   = 1'b1;
  localparam logic READ_DISABLE  = 1'b0;

  localparam logic [REG_BUS_W-1:0]  ZERO_WORD    = '0;
  localparam logic [REG_ADDR_W-1:0] NOP_REG_ADDR = '0;

  typedef logic [REG_BUS_W-1:0]  reg_bus_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/wb_regfile_hilo_reg.sv
// HI/LO pair: both halves always written together, with a combinational
// bypass so the value being written back is visible in the same cycle.
module hilo_reg
  import wb_regfile_pkg::*;
#(
  parameter int REG_WIDTH = REG_BUS_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [REG_WIDTH-1:0] hi_i,
  input  logic [REG_WIDTH-1:0] lo_i,
  output logic [REG_WIDTH-1:0] hi_o,
  output logic [REG_WIDTH-1:0] lo_o
);

  logic [REG_WIDTH-1:0] hi_q;
  logic [REG_WIDTH-1:0] hi_d;
  logic [REG_WIDTH-1:0] lo_q;
  logic [REG_WIDTH-1:0] lo_d;

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (we == WRITE_ENABLE) begin
      hi_d = hi_i;
      lo_d = lo_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      hi_q <= REG_WIDTH'(ZERO_WORD);
      lo_q <= REG_WIDTH'(ZERO_WORD);
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  // Reset forces zero outputs; otherwise the pending write wins over storage.
  always_comb begin
    hi_o = hi_q;
    lo_o = lo_q;
    if (rst == RST_ENABLE) begin
      hi_o = REG_WIDTH'(ZERO_WORD);
      lo_o = REG_WIDTH'(ZERO_WORD);
    end else if (we == WRITE_ENABLE) begin
      hi_o = hi_i;
      lo_o = lo_i;
    end
  end

endmodule

// File: rtl/wb_regfile.sv
// Write-back register file: GPR array with two bypassed read ports for ID,
// plus the HI/LO pair for EX. r0 is not stored and always reads zero.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int REG_WIDTH  = REG_BUS_W,
  parameter int REG_NUM    = wb_regfile_pkg::REG_NUM,
  parameter int ADDR_WIDTH = REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] wb_waddr,
  input  logic                  wb_we,
  input  logic [REG_WIDTH-1:0]  wb_wdata,
  input  logic                  wb_whilo,
  input  logic [REG_WIDTH-1:0]  wb_hi,
  input  logic [REG_WIDTH-1:0]  wb_lo,
  input  logic                  re1,
  input  logic [ADDR_WIDTH-1:0] raddr1,
  output logic [REG_WIDTH-1:0]  rdata1,
  input  logic                  re2,
  input  logic [ADDR_WIDTH-1:0] raddr2,
  output logic [REG_WIDTH-1:0]  rdata2,
  output logic [REG_WIDTH-1:0]  hi_o,
  output logic [REG_WIDTH-1:0]  lo_o
);

  logic [REG_WIDTH-1:0]  gpr_q  [1:REG_NUM-1];
  logic [REG_WIDTH-1:0]  gpr_d  [1:REG_NUM-1];
  logic [REG_WIDTH-1:0]  gpr_rd [REG_NUM];

  logic                  re_v    [2];
  logic [ADDR_WIDTH-1:0] raddr_v [2];
  logic [REG_WIDTH-1:0]  rdata_v [2];

  always_comb begin
    for (int i = 1; i < REG_NUM; i++) begin
      gpr_d[i] = gpr_q[i];
      if (wb_we == WRITE_ENABLE && wb_waddr == ADDR_WIDTH'(i)) begin
        gpr_d[i] = wb_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      for (int i = 1; i < REG_NUM; i++) begin
        gpr_q[i] <= REG_WIDTH'(ZERO_WORD);
      end
    end else begin
      for (int i = 1; i < REG_NUM; i++) begin
        gpr_q[i] <= gpr_d[i];
      end
    end
  end

  // Flat read view with r0 tied to zero, so the read muxes need no range guard.
  genvar gi;
  generate
    for (gi = 0; gi < REG_NUM; gi++) begin : g_rd_view
      if (gi == 0) begin : g_zero
        assign gpr_rd[gi] = REG_WIDTH'(ZERO_WORD);
      end else begin : g_reg
        assign gpr_rd[gi] = gpr_q[gi];
      end
    end
  endgenerate

  assign re_v[0]    = re1;
  assign re_v[1]    = re2;
  assign raddr_v[0] = raddr1;
  assign raddr_v[1] = raddr2;
  assign rdata1     = rdata_v[0];
  assign rdata2     = rdata_v[1];

  generate
    for (gi = 0; gi < 2; gi++) begin : g_rport
      always_comb begin
        rdata_v[gi] = gpr_rd[raddr_v[gi]];
        if (rst == RST_ENABLE) begin
          rdata_v[gi] = REG_WIDTH'(ZERO_WORD);
        end else if (re_v[gi] == READ_DISABLE) begin
          rdata_v[gi] = REG_WIDTH'(ZERO_WORD);
        end else if (raddr_v[gi] == ADDR_WIDTH'(NOP_REG_ADDR)) begin
          rdata_v[gi] = REG_WIDTH'(ZERO_WORD);
        end else if (wb_we == WRITE_ENABLE && wb_waddr == raddr_v[gi]) begin
          rdata_v[gi] = wb_wdata;
        end
      end
    end
  endgenerate

  hilo_reg #(
    .REG_WIDTH (REG_WIDTH)
  ) u_hilo_reg (
    .clk  (clk),
    .rst  (rst),
    .we   (wb_whilo),
    .hi_i (wb_hi),
    .lo_i (wb_lo),
    .hi_o (hi_o),
    .lo_o (lo_o)
  );

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: directed vectors with literal checks, plus a
// per-cycle comparison against an array model of the architectural state.
module tb_wb_regfile;

  logic        clk;
  logic        rst;
  logic [4:0]  wb_waddr;
  logic        wb_we;
  logic [31:0] wb_wdata;
  logic        wb_whilo;
  logic [31:0] wb_hi;
  logic [31:0] wb_lo;
  logic        re1;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic        re2;
  logic [4:0]  raddr2;
  logic [31:0] rdata2;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int tests_run = 0;
  int tests_failed = 0;
  bit done = 0;

  logic [31:0] m_gpr [32];
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  wb_regfile dut (
    .clk      (clk),
    .rst      (rst),
    .wb_waddr (wb_waddr),
    .wb_we    (wb_we),
    .wb_wdata (wb_wdata),
    .wb_whilo (wb_whilo),
    .wb_hi    (wb_hi),
    .wb_lo    (wb_lo),
    .re1      (re1),
    .raddr1   (raddr1),
    .rdata1   (rdata1),
    .re2      (re2),
    .raddr2   (raddr2),
    .rdata2   (rdata2),
    .hi_o     (hi_o),
    .lo_o     (lo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Architectural state after each edge, straight from the commit rules.
  initial begin
    for (int i = 0; i < 32; i++) m_gpr[i] = 32'h0;
    m_hi = 32'h0;
    m_lo = 32'h0;
  end

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) m_gpr[i] = 32'h0;
      m_hi = 32'h0;
      m_lo = 32'h0;
    end else begin
      if (wb_we && wb_waddr != 5'd0) m_gpr[wb_waddr] = wb_wdata;
      if (wb_whilo) begin
        m_hi = wb_hi;
        m_lo = wb_lo;
      end
    end
  end

  function automatic logic [31:0] exp_rd(input logic re, input logic [4:0] a);
    if (rst || !re || a == 5'd0) return 32'h0;
    if (wb_we && wb_waddr == a) return wb_wdata;
    return m_gpr[a];
  endfunction

  always @(negedge clk) begin
    if (!done) begin
      check("cyc_rdata1", rdata1, exp_rd(re1, raddr1));
      check("cyc_rdata2", rdata2, exp_rd(re2, raddr2));
      check("cyc_hi", hi_o, rst ? 32'h0 : (wb_whilo ? wb_hi : m_hi));
      check("cyc_lo", lo_o, rst ? 32'h0 : (wb_whilo ? wb_lo : m_lo));
    end
  end

  task automatic idle();
    wb_we = 1'b0; wb_waddr = 5'd0; wb_wdata = 32'h0;
    wb_whilo = 1'b0; wb_hi = 32'h0; wb_lo = 32'h0;
    re1 = 1'b0; raddr1 = 5'd0; re2 = 1'b0; raddr2 = 5'd0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of stimulus");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    idle();
    next_cycle();
    next_cycle();
    // Writes and reads during reset are masked
    wb_we = 1'b1; wb_waddr = 5'd5; wb_wdata = 32'h1111_2222;
    wb_whilo = 1'b1; wb_hi = 32'hAAAA_0000; wb_lo = 32'hBBBB_0000;
    re1 = 1'b1; raddr1 = 5'd5; re2 = 1'b1; raddr2 = 5'd5;
    #1;
    check("rst_rd1", rdata1, 32'h0);
    check("rst_rd2", rdata2, 32'h0);
    check("rst_hi", hi_o, 32'h0);
    check("rst_lo", lo_o, 32'h0);
    next_cycle();
    rst = 1'b0;
    idle();
    re1 = 1'b1; raddr1 = 5'd5;
    #1;
    check("rst_dropped_write", rdata1, 32'h0);

    // Reset clears a committed value
    $display("[TB] write r5=deadbeef");
    idle(); wb_we = 1'b1; wb_waddr = 5'd5; wb_wdata = 32'hDEAD_BEEF;
    next_cycle();
    idle(); re1 = 1'b1; raddr1 = 5'd5; re2 = 1'b1; raddr2 = 5'd5;
    #1;
    check("r5_written", rdata1, 32'hDEAD_BEEF);
    rst = 1'b1;
    #1;
    check("r5_rst_rd1", rdata1, 32'h0);
    check("r5_rst_rd2", rdata2, 32'h0);
    next_cycle();
    rst = 1'b0;
    #1;
    check("r5_after_rst", rdata1, 32'h0);

    // Write then read next cycle; re2=0 masks
    $display("[TB] write r3=12345678");
    idle(); wb_we = 1'b1; wb_waddr = 5'd3; wb_wdata = 32'h1234_5678;
    next_cycle();
    idle(); re2 = 1'b1; raddr2 = 5'd3;
    #1;
    check("r3_read", rdata2, 32'h1234_5678);
    re2 = 1'b0;
    #1;
    check("r3_re2_off", rdata2, 32'h0);

    // Same-cycle bypass on both ports; storage still old until the edge
    $display("[TB] bypass r7=a5a5a5a5");
    idle(); wb_we = 1'b1; wb_waddr = 5'd7; wb_wdata = 32'hA5A5_A5A5;
    re1 = 1'b1; raddr1 = 5'd7; re2 = 1'b1; raddr2 = 5'd7;
    #1;
    check("byp_rd1", rdata1, 32'hA5A5_A5A5);
    check("byp_rd2", rdata2, 32'hA5A5_A5A5);
    wb_we = 1'b0;
    #1;
    check("byp_old_storage", rdata1, 32'h0);
    wb_we = 1'b1;
    next_cycle();
    idle(); re1 = 1'b1; raddr1 = 5'd7;
    #1;
    check("byp_committed", rdata1, 32'hA5A5_A5A5);

    // r0 is immutable and never bypassed
    $display("[TB] write r0=ffffffff");
    idle(); wb_we = 1'b1; wb_waddr = 5'd0; wb_wdata = 32'hFFFF_FFFF;
    re1 = 1'b1; raddr1 = 5'd0; re2 = 1'b1; raddr2 = 5'd0;
    #1;
    check("r0_same_cycle", rdata1, 32'h0);
    next_cycle();
    idle(); re2 = 1'b1; raddr2 = 5'd0;
    #1;
    check("r0_next_cycle", rdata2, 32'h0);

    // HI/LO bypass and hold
    $display("[TB] hilo write 1/2");
    idle(); wb_whilo = 1'b1; wb_hi = 32'h1; wb_lo = 32'h2;
    #1;
    check("hilo_byp_hi", hi_o, 32'h1);
    check("hilo_byp_lo", lo_o, 32'h2);
    next_cycle();
    idle(); wb_hi = 32'h9;
    #1;
    check("hilo_hold_hi", hi_o, 32'h1);
    check("hilo_hold_lo", lo_o, 32'h2);

    // Simultaneous GPR and HI/LO commit, then bubbles
    $display("[TB] r31=55 hilo=66/77");
    idle(); wb_we = 1'b1; wb_waddr = 5'd31; wb_wdata = 32'h55;
    wb_whilo = 1'b1; wb_hi = 32'h66; wb_lo = 32'h77;
    next_cycle();
    for (int k = 0; k < 2; k++) begin
      idle(); re1 = 1'b1; raddr1 = 5'd31; re2 = 1'b1; raddr2 = 5'd3;
      #1;
      check("sim_r31", rdata1, 32'h55);
      check("sim_r3", rdata2, 32'h1234_5678);
      check("sim_hi", hi_o, 32'h66);
      check("sim_lo", lo_o, 32'h77);
      next_cycle();
    end

    // Sweep: write every register while reading neighbours, checked per cycle
    for (int i = 1; i < 32; i++) begin
      idle();
      wb_we = 1'b1; wb_waddr = 5'(i); wb_wdata = (32'(i) * 32'h0101_0101) ^ 32'hC3;
      re1 = 1'b1; raddr1 = 5'(i - 1);
      re2 = (i % 3) != 0; raddr2 = 5'(i);
      wb_whilo = (i % 4) == 0; wb_hi = 32'(i) << 8; wb_lo = ~32'(i);
      $display("[TB] sweep write r%0d=%h", i, wb_wdata);
      next_cycle();
    end
    for (int i = 0; i < 32; i++) begin
      idle(); re1 = 1'b1; raddr1 = 5'(i); re2 = 1'b1; raddr2 = 5'(31 - i);
      next_cycle();
    end
    idle(); re1 = 1'b1; raddr1 = 5'd4;
    #1;
    check("sweep_r4", rdata1, 32'h0404_04C7);
    check("sweep_hi", hi_o, 32'h1C00);
    next_cycle();

    done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
Write-back end of the MEM/WB pipeline register. Commits the registered write-back bundle (GPR write, HI/LO write) into architectural state at the clock edge. Serves the two GPR read ports used by ID, plus the HI/LO values used by EX. Same-cycle write-to-read bypass is built in, so ID/EX see a value in the cycle it is written back.

Parameters:
REG_WIDTH, 32, data width of GPRs, HI and LO
REG_NUM, 32, number of GPRs; index 0 hardwired to zero
ADDR_WIDTH, 5, GPR address width; must equal clog2(REG_NUM)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high (RstEnable = 1)
wb_waddr  input  ADDR_WIDTH  GPR write address from MEM/WB
wb_we  input  1  GPR write enable
wb_wdata  input  REG_WIDTH  GPR write data
wb_whilo  input  1  HI/LO write enable
wb_hi  input  REG_WIDTH  HI write data
wb_lo  input  REG_WIDTH  LO write data
re1  input  1  read port 1 enable
raddr1  input  ADDR_WIDTH  read port 1 address
rdata1  output  REG_WIDTH  read port 1 data (combinational)
re2  input  1  read port 2 enable
raddr2  input  ADDR_WIDTH  read port 2 address
rdata2  output  REG_WIDTH  read port 2 data (combinational)
hi_o  output  REG_WIDTH  current HI (combinational, bypassed)
lo_o  output  REG_WIDTH  current LO (combinational, bypassed)

Behaviour:
- Storage: GPR[1..REG_NUM-1], HI, LO. GPR[0] is not stored and always reads 0.
- Reset: at a posedge with rst=1, all GPRs, HI and LO become 0. Writes presented in that cycle are dropped. While rst=1, rdata1, rdata2, hi_o and lo_o are driven to 0, independent of the other inputs. Reset mid-stream needs no further cleanup; the first edge after rst falls behaves normally.
- GPR write: at a posedge with rst=0, wb_we=1 and wb_waddr!=0, GPR[wb_waddr] <= wb_wdata. A write to address 0 is ignored silently.
- HI/LO write: at a posedge with rst=0 and wb_whilo=1, HI <= wb_hi and LO <= wb_lo. Both are always written together; there is no partial HI/LO write.
- GPR and HI/LO writes are independent and may occur in the same cycle.
- Read port n, combinational, evaluated in priority order:
  1. rst=1 -> 0
  2. re_n=0 -> 0
  3. raddr_n=0 -> 0
  4. wb_we=1 and wb_waddr==raddr_n -> wb_wdata (bypass)
  5. otherwise -> GPR[raddr_n]
- Both read ports may address the same register, or the write address, at once. Each port bypasses independently.
- hi_o/lo_o: rst=1 -> 0; wb_whilo=1 -> wb_hi/wb_lo (bypass); otherwise HI/LO.
- Latency: write-to-read is 0 cycles through the bypass; the stored value is visible from the next cycle on.
- The bubble pattern from MEM/WB (we=0, waddr=NOPRegAddr, data=0) must cause no state change.
- No X propagation: reads of never-written registers return their reset value, 0.

Decomposition:
- Shared defines file holds: RstEnable, WriteEnable/WriteDisable, ReadEnable/ReadDisable, ZeroWord, NOPRegAddr, RegBus, RegAddrBus, RegNum. Reuse these; no new literals.
- One natural sub-module, hilo_reg: holds HI/LO with reset, write and bypass. The GPR array and its two read muxes stay in wb_regfile.

Test Plan:
- Reset clears state: write GPR[5]=0xDEADBEEF, assert rst one cycle, release, read raddr1=5 with re1=1 -> rdata1=0. During rst, rdata1, rdata2, hi_o and lo_o are all 0.
- Write then read: wb_we=1, wb_waddr=3, wb_wdata=0x12345678 at edge N. Read port 2 address 3 at cycle N+1 -> 0x12345678. With re2=0 -> 0.
- Bypass: in the same cycle as wb_we=1, wb_waddr=7, wb_wdata=0xA5A5A5A5, drive raddr1=raddr2=7 -> both read 0xA5A5A5A5 before the edge. The old value (0) remains in storage until the edge.
- r0 immutable: wb_we=1, wb_waddr=0, wb_wdata=0xFFFFFFFF. Read address 0 in the same and the next cycle -> 0; no bypass.
- HI/LO: wb_whilo=1, wb_hi=0x1, wb_lo=0x2 -> hi_o/lo_o show 1/2 combinationally and after the edge. Next cycle wb_whilo=0, wb_hi=0x9 -> hi_o stays 1.
- Simultaneous and bubble: the same cycle writes GPR[31]=0x55 and HI/LO=0x66/0x77 -> all three are committed. A following bubble cycle (we=0, whilo=0) leaves all values unchanged.
